alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-side consumer of the 3-bit ALU control code produced by the ALU decoder.
- Accepts operand pairs plus a control code over a valid/ready handshake and computes ADD, SUB, AND, OR or SLT.
- Returns a registered result, a zero flag (for BEQ/BNE) and an illegal-code flag over a second valid/ready handshake.
- Contains a 2-entry output buffer (output register + skid register): full throughput under backpressure, fully registered o_ready.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2).
- TAG_W, 5, width of the opaque tag carried with each operation (e.g. rd index).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous discard of all buffered and incoming operations.
- i_valid  input  1  upstream operation valid.
- o_ready  output  1  unit can accept an operation this cycle.
- i_alucrtl  input  3  ALU control code.
- i_srca  input  WIDTH  operand A.
- i_srcb  input  WIDTH  operand B.
- i_tag  input  TAG_W  tag, returned unchanged.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  WIDTH  ALU result.
- o_zero  output  1  result == 0 (forced 0 when o_illegal).
- o_illegal  output  1  control code was not a defined operation.
- o_tag  output  TAG_W  tag of the presented result.

Behaviour:
- Code map:
  - 000 ADD: A+B mod 2^WIDTH.
  - 001 SUB: A−B mod 2^WIDTH.
  - 010 AND.
  - 011 OR.
  - 101 SLT: {WIDTH-1 zeros, signed(A)<signed(B)}.
  - 100/110/111 or any X/Z bit: o_result=0, o_zero=0, o_illegal=1.
- Accept = i_valid & o_ready. Compute is combinational on input; result, flags and tag are registered.
- Latency: accepted in cycle N, presented with o_valid=1 in cycle N+1 when the output register is free or drains in cycle N.
- Storage: output register (OR) drives o_*; skid register (SK) holds one overflow entry.
- o_ready = ~SK.valid, driven from a flop with no combinational path from i_ready.
- Per-cycle update, with drain = OR.valid & i_ready:
  - OR empty or drain, SK empty: the accepted op (if any) loads OR; otherwise OR.valid clears on drain.
  - OR empty or drain, SK full: SK moves to OR; the accepted op (if any) loads SK.
  - OR full, no drain: the accepted op loads SK. Acceptance is only possible when SK is empty.
- Order is strictly FIFO; no drop, no duplication. Sustained throughput is 1 op/cycle while i_ready=1.
- o_valid holds and o_* stay stable while o_valid & ~i_ready; required handshake rule.
- i_flush=1: OR.valid and SK.valid clear next cycle. An op accepted that cycle is discarded. o_ready=1 next cycle. i_flush has priority over accept and drain.
- Reset (i_rst=1, synchronous, highest priority), values in the following cycle:
  - o_valid=0, SK.valid=0, o_ready=1.
  - o_result=0, o_zero=0, o_illegal=0, o_tag=0.
  - Reset mid-stream drops all in-flight ops.
- Data flops need no reset; o_* data outputs are masked to 0 while o_valid=0.
- Tag is carried unmodified, including on illegal ops.

Decomposition:
- alu_pkg:
  - typedef enum logic [2:0] alucrtl_e {ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101}.
  - Function is_legal_alucrtl().
  - Shared with the ALU decoder.
- Sub-module alu_core: purely combinational (crtl, a, b) -> (result, zero, illegal).
- alu_exec_unit owns the handshake, OR/SK registers and flush/reset.

Test Plan:
1. Reset then single ops, i_ready=1:
   - ADD 7+5 -> o_result=12, o_zero=0, one cycle later.
   - SUB 5−5 -> 0, o_zero=1.
   - SUB 0−1 -> 0xFFFFFFFF.
2. Logic and compare ops:
   - AND 0xF0F0&0x0FF0=0x00F0; OR -> 0xFFF0.
   - SLT −1 vs 1 -> 1; SLT 1 vs −1 -> 0.
   - SLT 0x7FFFFFFF vs 0x80000000 -> 0.
3. Illegal codes 100/110/111 with tag 9 -> o_result=0, o_zero=0, o_illegal=1, o_tag=9.
4. Backpressure: stream tags 1..6 back-to-back, i_ready=0 for 3 cycles mid-stream.
   - o_ready drops exactly when SK fills.
   - o_* stable while stalled.
   - Output tags arrive in order 1..6, none lost or duplicated.
   - Throughput 1/cycle once i_ready=1.
5. Flush with OR and SK full plus a simultaneous i_valid -> next cycle o_valid=0, o_ready=1; the next op is first out.
6. i_rst asserted with 2 ops buffered -> next cycle o_valid=0, o_result=0, o_ready=1; a post-reset ADD 1+1 -> 2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code encoding used by the decoder and the execute unit.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alucrtl_e;

    // True only for the five defined codes; codes with X/Z bits match no item and fall to default.
    function automatic logic is_legal_alucrtl(input logic [2:0] crtl);
        case (crtl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: (control, A, B) -> (result, zero, illegal).
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_crtl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_illegal
);

    // Operation select; undefined codes yield a zero result and raise illegal.
    always_comb begin
        o_illegal = ~is_legal_alucrtl(i_crtl);
        o_result  = '0;
        case (i_crtl)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            default: o_result = '0;
        endcase
        o_zero = ~o_illegal & (o_result == '0);
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute unit: valid/ready in, registered result out, 2-entry output/skid buffer.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_alucrtl,
    input  logic [WIDTH-1:0] i_srca,
    input  logic [WIDTH-1:0] i_srcb,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    // Buffer entry layout: {tag, illegal, zero, result}
    localparam int ENT_W = TAG_W + 2 + WIDTH;

    logic [WIDTH-1:0] w_core_result;
    logic             w_core_zero;
    logic             w_core_illegal;
    logic [ENT_W-1:0] w_new_ent;

    logic             r_or_valid;
    logic             r_sk_valid;
    logic             r_ready;
    logic [ENT_W-1:0] r_or_ent;
    logic [ENT_W-1:0] r_sk_ent;

    logic w_accept;
    logic w_drain;
    logic w_or_free;
    logic w_or_load_sk;
    logic w_or_load_new;
    logic w_sk_load_new;
    logic w_or_valid_nxt;
    logic w_sk_valid_nxt;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_crtl    (i_alucrtl),
        .i_a       (i_srca),
        .i_b       (i_srcb),
        .o_result  (w_core_result),
        .o_zero    (w_core_zero),
        .o_illegal (w_core_illegal)
    );

    assign w_new_ent = {i_tag, w_core_illegal, w_core_zero, w_core_result};
    assign w_accept  = i_valid & r_ready;
    assign w_drain   = r_or_valid & i_ready;
    assign w_or_free = ~r_or_valid | w_drain;

    // Next-state steering for the output and skid registers; flush overrides everything.
    always_comb begin
        w_or_load_sk   = 1'b0;
        w_or_load_new  = 1'b0;
        w_sk_load_new  = 1'b0;
        w_or_valid_nxt = r_or_valid;
        w_sk_valid_nxt = r_sk_valid;
        if (w_or_free) begin
            if (r_sk_valid) begin
                w_or_load_sk   = 1'b1;
                w_or_valid_nxt = 1'b1;
                w_sk_load_new  = w_accept;
                w_sk_valid_nxt = w_accept;
            end else begin
                w_or_load_new  = w_accept;
                w_or_valid_nxt = w_accept;
                w_sk_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_sk_load_new  = 1'b1;
            w_sk_valid_nxt = 1'b1;
        end
        if (i_flush) begin
            w_or_valid_nxt = 1'b0;
            w_sk_valid_nxt = 1'b0;
        end
    end

    // Valid bits and the registered ready; ready mirrors next skid emptiness so it never sees i_ready combinationally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_or_valid <= w_or_valid_nxt;
            r_sk_valid <= w_sk_valid_nxt;
            r_ready    <= ~w_sk_valid_nxt;
        end
    end

    // Data payloads carry no reset; their validity is tracked by the valid bits.
    always_ff @(posedge i_clk) begin
        if (w_or_load_sk) begin
            r_or_ent <= r_sk_ent;
        end else if (w_or_load_new) begin
            r_or_ent <= w_new_ent;
        end
        if (w_sk_load_new) begin
            r_sk_ent <= w_new_ent;
        end
    end

    assign o_ready   = r_ready;
    assign o_valid   = r_or_valid;
    assign o_result  = r_or_valid ? r_or_ent[WIDTH-1:0]       : '0;
    assign o_zero    = r_or_valid ? r_or_ent[WIDTH]           : 1'b0;
    assign o_illegal = r_or_valid ? r_or_ent[WIDTH+1]         : 1'b0;
    assign o_tag     = r_or_valid ? r_or_ent[ENT_W-1 -: TAG_W] : '0;

endmodule
